// File: rtl/sar_comp_seq.sv
// Successive-approximation sequencer for a dynamic latched comparator.
// It phases the comparator, synchronizes the decision, builds the code and returns it over valid/ready.
module sar_comp_seq #(
  parameter int N_BITS        = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int EVAL_TIMEOUT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              comp_clk,
  output logic              comp_clkb,
  input  logic              comp_outp,
  input  logic              comp_outn,
  output logic [N_BITS-1:0] dac_code,
  output logic [N_BITS-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              meta_err
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [N_BITS-1:0] MSB_CODE   = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [3:0]        SETTLE_MIN = 4'(SETTLE_CYCLES);
  localparam logic [3:0]        EVAL_LAST  = 4'(EVAL_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_MSB    = IDX_W'(N_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    EVAL   = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [IDX_W-1:0]  bit_idx_r;
  logic              bit_val_r;
  logic              outp_meta_r, outn_meta_r, outp_sync_r, outn_sync_r;
  logic              dec_v_s, settle_done_s, eval_done_s, comp_clk_nxt_s;
  logic [N_BITS-1:0] code_res_s, code_next_s;

  // Decision qualification, comparator phase for next cycle and next trial code
  always_comb begin
    dec_v_s       = outp_sync_r ^ outn_sync_r;
    settle_done_s = (state_r == SETTLE) && (cnt_r >= SETTLE_MIN) && outp_sync_r && outn_sync_r;
    eval_done_s   = (state_r == EVAL) && (dec_v_s || (cnt_r == EVAL_LAST));
    // The comparator evaluates only from the settled SETTLE exit until EVAL resolves
    comp_clk_nxt_s = settle_done_s || ((state_r == EVAL) && !eval_done_s);
    code_res_s            = dac_code;
    code_res_s[bit_idx_r] = bit_val_r;
    code_next_s           = code_res_s;
    if (bit_idx_r != IDX_ZERO) begin
      code_next_s[bit_idx_r - IDX_ONE] = 1'b1;
    end else begin
      code_next_s = code_res_s;
    end
  end

  // Synchronizers, comparator phase flops and conversion state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      bit_idx_r    <= IDX_ZERO;
      bit_val_r    <= 1'b0;
      outp_meta_r  <= 1'b1;
      outn_meta_r  <= 1'b1;
      outp_sync_r  <= 1'b1;
      outn_sync_r  <= 1'b1;
      comp_clk     <= 1'b0;
      comp_clkb    <= 1'b1;
      busy         <= 1'b0;
      dac_code     <= {N_BITS{1'b0}};
      result       <= {N_BITS{1'b0}};
      result_valid <= 1'b0;
      meta_err     <= 1'b0;
    end else begin
      outp_meta_r <= comp_outp;
      outn_meta_r <= comp_outn;
      outp_sync_r <= outp_meta_r;
      outn_sync_r <= outn_meta_r;
      comp_clk    <= comp_clk_nxt_s;
      comp_clkb   <= ~comp_clk_nxt_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            meta_err  <= 1'b0;
            dac_code  <= MSB_CODE;
            bit_idx_r <= IDX_MSB;
            cnt_r     <= 4'd0;
            busy      <= 1'b1;
            state_r   <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done_s) begin
            cnt_r   <= 4'd0;
            state_r <= EVAL;
          end else if (cnt_r != 4'hF) begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        EVAL: begin
          // A real decision takes priority over a coincident timeout
          if (dec_v_s) begin
            bit_val_r <= outp_sync_r;
            state_r   <= DECIDE;
          end else if (cnt_r == EVAL_LAST) begin
            bit_val_r <= 1'b0;
            meta_err  <= 1'b1;
            state_r   <= DECIDE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        DECIDE: begin
          dac_code <= code_next_s;
          if (bit_idx_r != IDX_ZERO) begin
            bit_idx_r <= bit_idx_r - IDX_ONE;
            cnt_r     <= 4'd0;
            state_r   <= SETTLE;
          end else begin
            result       <= code_res_s;
            result_valid <= 1'b1;
            state_r      <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
